// File: rtl/led_blink_sched.sv
// rtl/led_blink_sched.sv - shared-prescaler round-robin LED blink scheduler
//
// One prescaler produces a tick every DIV = CLOCK_HZ/TICK_HZ cycles. After each
// tick, a single decrement datapath visits channels 0..NCH-1, one per cycle.
// An enabled channel with half-period P toggles its LED once every P ticks.
//
// Optional feature: define SYNC_RESTART_EN to add i_sync, which (in IDLE)
// restarts the prescaler, reloads every channel's phase and clears all LEDs.
//
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_cfg_valid/ready    config write handshake (accepted only in IDLE)
//   i_cfg_ch             channel to configure
//   i_cfg_period         half-period in ticks (0 = frozen)
//   i_cfg_enable         channel enable
//   i_sync               phase restart request (SYNC_RESTART_EN only)
//   o_led                registered LED outputs
//   o_tick               registered one-cycle prescaler pulse
//   o_busy               high during the NCH-cycle scan

module led_blink_sched #(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NCH      = 4,
    parameter int PWIDTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [$clog2(NCH)-1:0]  i_cfg_ch,
    input  logic [PWIDTH-1:0]       i_cfg_period,
    input  logic                    i_cfg_enable,
`ifdef SYNC_RESTART_EN
    input  logic                    i_sync,
`endif
    output logic [NCH-1:0]          o_led,
    output logic                    o_tick,
    output logic                    o_busy
);

    localparam int DIV = CLOCK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(NCH);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

    // A scan must finish before the next tick arrives.
    if (DIV < NCH + 2) begin : g_div_check
        $error("led_blink_sched: CLOCK_HZ/TICK_HZ must be >= NCH+2");
    end

    if (NCH < 2 || NCH > 16 || (NCH & (NCH - 1)) != 0) begin : g_nch_check
        $error("led_blink_sched: NCH must be a power of two in 2..16");
    end

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [PWIDTH-1:0]  period_q [NCH];
    logic [PWIDTH-1:0]  remain_q [NCH];
    logic [NCH-1:0]     enable_q;
    logic               sync_req;
    logic               wr_fire;

`ifdef SYNC_RESTART_EN
    assign sync_req = i_sync && !o_busy;
`else
    assign sync_req = 1'b0;
`endif

    // Ready follows the registered busy flag; it is forced low during reset
    // and during a sync restart so no write can race those.
    assign o_cfg_ready = !o_busy && !i_reset && !sync_req;
    assign wr_fire     = i_cfg_valid && o_cfg_ready;

    // Reload value for a fresh phase: period-1, clamped at 0.
    function automatic logic [PWIDTH-1:0] reload(input logic [PWIDTH-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            enable_q <= '0;
            o_led    <= '0;
            o_tick   <= 1'b0;
            o_busy   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                period_q[k] <= '0;
                remain_q[k] <= '0;
            end
        end else begin
            // Prescaler: the tick register goes high the cycle after the
            // count reaches DIV-1.
            if (sync_req) begin
                cnt    <= '0;
                o_tick <= 1'b0;
            end else begin
                o_tick <= (cnt == CNT_LAST);
                cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (sync_req) begin
                        o_led <= '0;
                        for (int k = 0; k < NCH; k++) begin
                            remain_q[k] <= reload(period_q[k]);
                        end
                    end else if (wr_fire) begin
                        period_q[i_cfg_ch] <= i_cfg_period;
                        remain_q[i_cfg_ch] <= reload(i_cfg_period);
                        enable_q[i_cfg_ch] <= i_cfg_enable;
                        o_led[i_cfg_ch]    <= 1'b0;
                    end
                    // A write in the tick cycle lands first, so the scan
                    // that follows already sees it.
                    if (o_tick) begin
                        state  <= S_SCAN;
                        o_busy <= 1'b1;
                        idx    <= '0;
                    end
                end

                S_SCAN: begin
                    if (enable_q[idx] && period_q[idx] != '0) begin
                        if (remain_q[idx] == '0) begin
                            o_led[idx]    <= ~o_led[idx];
                            remain_q[idx] <= period_q[idx] - 1'b1;
                        end else begin
                            remain_q[idx] <= remain_q[idx] - 1'b1;
                        end
                    end
                    // NCH is a power of two, so idx wraps back to 0 here.
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
